dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 16-bit data memory between two requesters: port 0 =
//  CPU load/store path, port 1 = host/debug loader (preloads and dumps DataMem).
//  Round-robin arbitration, one access per cycle; the memory has a 1-cycle read.
//  Drives cpu_stall, which holds the CPU's PC while its access is pending.
// PARAMETERS
//  ADDR_W  9   word-address width (512-word DataMem)
//  DATA_W  16  data word width
// PORTS
//  clock       in   1       system clock, all state on posedge
//  reset       in   1       asynchronous, active-high
//  req0        in   1       CPU access request; we0/addr0/wdata0 stable until gnt0
//  we0         in   1       1 = write, 0 = read
//  addr0       in   ADDR_W  CPU word address
//  wdata0      in   DATA_W  CPU write data
//  gnt0        out  1       CPU access issued to memory this cycle
//  rvalid0     out  1       CPU read data valid (cycle after a read gnt0)
//  rdata0      out  DATA_W  CPU read data
//  req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1   same as port 0, host side
//  cpu_stall   out  1       req0 & ~gnt0
//  mem_en      out  1       memory access strobe
//  mem_we      out  1       memory write enable
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data, valid the cycle after mem_en & ~mem_we
// BEHAVIOUR
//  - Reset: gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, mem_en=mem_we=0,
//    mem_addr=mem_wdata=0, last=1 (so the CPU wins the first tie).
//  - gnt0/gnt1 are combinational from req0, req1 and register `last`; never both 1.
//    Only req0 -> gnt0; only req1 -> gnt1; both -> the port != last.
//  - On the grant cycle: mem_en=1; mem_we/addr/wdata mux from the granted port;
//    last <= granted port at the posedge. No request: mem_en=0, last unchanged.
//  - Read latency: rvalid<n> is 1 for exactly one cycle, the cycle after a read
//    grant; rdata<n> = mem_rdata in that cycle, registered and held until the next
//    read completion on that port. Writes never assert rvalid.
//  - Back-to-back: a port whose req stays high after a grant competes again the
//    next cycle; with both active, grants strictly alternate 0,1,0,1...
//  - Read-after-write, same address, consecutive cycles: the read returns the
//    newly written data (memory writes at the grant posedge).
//  - A requester must not change we/addr/wdata while req=1 & gnt=0; dropping req
//    before gnt is legal and cancels the request with no memory access.
//  - Reset asserted mid-operation: in-flight read data is discarded (no rvalid
//    after reset deasserts); last returns to 1; memory contents are untouched.
//  - Two-state pipeline per port: IDLE -> (read gnt) RESP -> IDLE; a new grant
//    may issue during RESP (full throughput, one access per cycle).
// TESTING
//  1 Reset: hold reset, toggle all reqs -> every output 0; release -> idle, mem_en=0.
//  2 CPU read only: req0=1,we0=0,addr0=0 (mem[0]=16'h0007) -> gnt0 same cycle,
//    cpu_stall=0, next cycle rvalid0=1, rdata0=16'h0007.
//  3 Contention: req0 and req1 both held for 4 cycles from reset -> grants 0,1,0,1;
//    cpu_stall=1 exactly on the port-1 cycles.
//  4 Host write then CPU read: host writes 16'h00A5 to addr 5; next cycle CPU reads
//    addr 5 -> rdata0=16'h00A5, rvalid1 never asserted.
//  5 Reset mid-read: gnt1 read of addr 1, assert reset before the next posedge ->
//    rvalid1 stays 0 after release, rdata1=0.
//  6 Request drop: req1=1 while port 0 holds the grant, then req1=0 -> no gnt1,
//    no host-side memory access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing single-port DataMem between CPU and host
module dmem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, RESP} portState_t;

  portState_t        state0, state1;
  logic              last;
  logic [DATA_W-1:0] hold0, hold1;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    gnt0 = ~reset & req0 & (~req1 | last);
    gnt1 = ~reset & req1 & (~req0 | ~last);
  end

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign cpu_stall = ~reset & req0 & ~gnt0;
  assign rvalid0   = (state0 == RESP);
  assign rvalid1   = (state1 == RESP);

  // Memory data is only valid in the response cycle; afterwards the captured copy is shown.
  assign rdata0 = rvalid0 ? mem_rdata : hold0;
  assign rdata1 = rvalid1 ? mem_rdata : hold1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last   <= 1'b1;
      state0 <= IDLE;
      state1 <= IDLE;
      hold0  <= '0;
      hold1  <= '0;
    end else begin
      if (gnt0) begin
        last <= 1'b0;
      end else if (gnt1) begin
        last <= 1'b1;
      end
      state0 <= (gnt0 & ~we0) ? RESP : IDLE;
      state1 <= (gnt1 & ~we1) ? RESP : IDLE;
      if (state0 == RESP) begin
        hold0 <= mem_rdata;
      end
      if (state1 == RESP) begin
        hold1 <= mem_rdata;
      end
    end
  end

endmodule
